// File: rtl/module_control_operandos.sv
// Operand entry sequencer between the keypad decoder and the multiplier.
// It builds two decimal operands from key events, starts the multiplier, and holds the result.
//
// state  | meaning
// CAP_A  | accumulating digits of operand A
// CAP_B  | accumulating digits of operand B
// MULT   | multiplier launched, waiting for its done flag
// RESULT | product available, operands held until restart
module module_control_operandos #(
  parameter int MAX_DIGITOS = 2,
  parameter int OP_W        = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dato_listo_i,
  input  logic [3:0]      dato_i,
  input  logic            mult_listo_i,
  output logic            mult_start_o,
  output logic [OP_W-1:0] operando_a_o,
  output logic [OP_W-1:0] operando_b_o,
  output logic [1:0]      digitos_o,
  output logic [1:0]      estado_o
);

  typedef enum logic [1:0] {
    CAP_A  = 2'b00,
    CAP_B  = 2'b01,
    MULT   = 2'b10,
    RESULT = 2'b11
  } estado_t;

  localparam logic [3:0] TECLA_CONF = 4'd15;
  localparam logic [3:0] TECLA_MAX  = 4'd9;
  localparam logic [1:0] MAX_D      = 2'(MAX_DIGITOS);

  estado_t         estado_q, estado_d;
  logic [OP_W-1:0] op_a_q, op_a_d;
  logic [OP_W-1:0] op_b_q, op_b_d;
  logic [1:0]      dig_q, dig_d;
  logic            start_q, start_d;
  logic            listo_q;

  logic            evt;
  logic            es_digito;
  logic            es_conf;
  logic [OP_W-1:0] op_sel;
  logic [OP_W-1:0] op_x10;
  logic [OP_W-1:0] dato_ext;

  // Rising edge of the key-valid level; listo_q resets high so a held key is not taken
  assign evt       = dato_listo_i & ~listo_q;
  assign es_digito = (dato_i <= TECLA_MAX);
  assign es_conf   = (dato_i == TECLA_CONF);
  assign dato_ext  = OP_W'(dato_i);
  assign op_sel    = (estado_q == CAP_B) ? op_b_q : op_a_q;
  assign op_x10    = (op_sel << 3) + (op_sel << 1) + dato_ext;

  always_comb begin
    estado_d = estado_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    dig_d    = dig_q;
    start_d  = 1'b0;

    case (estado_q)
      CAP_A: begin
        if (evt) begin
          if (es_digito && (dig_q < MAX_D)) begin
            op_a_d = op_x10;
            dig_d  = dig_q + 2'd1;
          end else if (es_conf && (dig_q != 2'd0)) begin
            dig_d    = 2'd0;
            estado_d = CAP_B;
          end
        end
      end

      CAP_B: begin
        if (evt) begin
          if (es_digito && (dig_q < MAX_D)) begin
            op_b_d = op_x10;
            dig_d  = dig_q + 2'd1;
          end else if (es_conf && (dig_q != 2'd0)) begin
            dig_d    = 2'd0;
            estado_d = MULT;
            start_d  = 1'b1;
          end
        end
      end

      MULT: begin
        // The done flag is ignored during the start cycle itself
        if (!start_q && mult_listo_i) begin
          estado_d = RESULT;
        end
      end

      RESULT: begin
        if (evt) begin
          if (es_conf) begin
            op_a_d   = '0;
            op_b_d   = '0;
            dig_d    = 2'd0;
            estado_d = CAP_A;
          end else if (es_digito) begin
            op_a_d   = dato_ext;
            op_b_d   = '0;
            dig_d    = 2'd1;
            estado_d = CAP_A;
          end
        end
      end

      default: begin
        estado_d = CAP_A;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= CAP_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      dig_q    <= 2'd0;
      start_q  <= 1'b0;
      listo_q  <= 1'b1;
    end else begin
      estado_q <= estado_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      dig_q    <= dig_d;
      start_q  <= start_d;
      listo_q  <= dato_listo_i;
    end
  end

  assign mult_start_o = start_q;
  assign operando_a_o = op_a_q;
  assign operando_b_o = op_b_q;
  assign digitos_o    = dig_q;
  assign estado_o     = estado_q;

endmodule

// File: tb/tb_module_control_operandos.sv
// Scoreboard bench for module_control_operandos: every expected output change is queued
// by the stimulus and popped by a monitor whenever the DUT outputs change.
module tb_module_control_operandos;

  logic       clk = 1'b0;
  logic       rst;
  logic       dato_listo_i;
  logic [3:0] dato_i;
  logic       mult_listo_i;
  logic       mult_start_o;
  logic [6:0] operando_a_o;
  logic [6:0] operando_b_o;
  logic [1:0] digitos_o;
  logic [1:0] estado_o;

  always #5 clk = ~clk;

  module_control_operandos #(.MAX_DIGITOS(2), .OP_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .dato_listo_i (dato_listo_i),
    .dato_i       (dato_i),
    .mult_listo_i (mult_listo_i),
    .mult_start_o (mult_start_o),
    .operando_a_o (operando_a_o),
    .operando_b_o (operando_b_o),
    .digitos_o    (digitos_o),
    .estado_o     (estado_o)
  );

  typedef struct packed {
    logic [1:0] est;
    logic [6:0] a;
    logic [6:0] b;
    logic [1:0] dig;
    logic       st;
  } snap_t;

  typedef struct {
    snap_t s;
    string name;
  } exp_t;

  exp_t  exp_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  bit    mon_en       = 1'b0;
  snap_t last;
  snap_t cur;
  exp_t  e;

  function automatic snap_t mk(logic [1:0] est, logic [6:0] a, logic [6:0] b,
                               logic [1:0] dig, logic st);
    snap_t s;
    s.est = est; s.a = a; s.b = b; s.dig = dig; s.st = st;
    return s;
  endfunction

  task automatic push(string n, logic [1:0] est, logic [6:0] a, logic [6:0] b,
                      logic [1:0] dig, logic st);
    exp_t x;
    x.s    = mk(est, a, b, dig, st);
    x.name = n;
    exp_q.push_back(x);
  endtask

  task automatic check(string n, logic [31:0] act, logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  task automatic press(logic [3:0] k);
    @(posedge clk); #1;
    dato_i       = k;
    dato_listo_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dato_listo_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Monitor: any change of the observable outputs consumes one expectation
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {estado_o, operando_a_o, operando_b_o, digitos_o, mult_start_o};
      if (cur !== last) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_change: got est=%0d a=%0d b=%0d dig=%0d start=%0d, no change expected",
                   cur.est, cur.a, cur.b, cur.dig, cur.st);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.s) begin
            tests_failed++;
            $display("FAIL %s: got est=%0d a=%0d b=%0d dig=%0d start=%0d expected est=%0d a=%0d b=%0d dig=%0d start=%0d",
                     e.name, cur.est, cur.a, cur.b, cur.dig, cur.st,
                     e.s.est, e.s.a, e.s.b, e.s.dig, e.s.st);
          end
        end
        last = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  initial begin
    // Test 1: key held through reset must not be captured
    rst          = 1'b0;
    dato_listo_i = 1'b1;
    dato_i       = 4'd5;
    mult_listo_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", 32'(operando_a_o), 32'd0);
    check("rst_b", 32'(operando_b_o), 32'd0);
    check("rst_estado", 32'(estado_o), 32'd0);
    check("rst_digitos", 32'(digitos_o), 32'd0);
    check("rst_start", 32'(mult_start_o), 32'd0);
    dato_listo_i = 1'b0;
    repeat (2) @(posedge clk);
    last   = mk(2'd0, 7'd0, 7'd0, 2'd0, 1'b0);
    mon_en = 1'b1;

    // Test 2: 4 2 # 7 # with held strobes
    push("a_digit4", 2'd0, 7'd4, 7'd0, 2'd1, 1'b0);   press(4'd4);
    push("a_digit2", 2'd0, 7'd42, 7'd0, 2'd2, 1'b0);  press(4'd2);
    push("conf_a", 2'd1, 7'd42, 7'd0, 2'd0, 1'b0);    press(4'd15);
    push("b_digit7", 2'd1, 7'd42, 7'd7, 2'd1, 1'b0);  press(4'd7);
    push("start_hi", 2'd2, 7'd42, 7'd7, 2'd0, 1'b1);
    push("start_lo", 2'd2, 7'd42, 7'd7, 2'd0, 1'b0);
    press(4'd15);

    // Test 4: keys ignored in MULT, wait for done flag
    press(4'd3);
    repeat (20) @(posedge clk);
    #1 mult_listo_i = 1'b1;
    push("to_result", 2'd3, 7'd42, 7'd7, 2'd0, 1'b0);
    check("mult_hold_estado", 32'(estado_o), 32'd2);
    @(posedge clk); #1;
    check("result_latency", 32'(estado_o), 32'd3);
    mult_listo_i = 1'b0;

    // Test 5a: digit in RESULT restarts with that digit
    push("restart_digit", 2'd0, 7'd6, 7'd0, 2'd1, 1'b0);  press(4'd6);
    push("conf_a2", 2'd1, 7'd6, 7'd0, 2'd0, 1'b0);        press(4'd15);
    press(4'd15);  // empty operand B: ignored
    check("empty_conf_estado", 32'(estado_o), 32'd1);
    push("b_digit1", 2'd1, 7'd6, 7'd1, 2'd1, 1'b0);       press(4'd1);
    // Done flag already high at launch: ignored in the start cycle only
    mult_listo_i = 1'b1;
    push("start2_hi", 2'd2, 7'd6, 7'd1, 2'd0, 1'b1);
    push("start2_lo", 2'd2, 7'd6, 7'd1, 2'd0, 1'b0);
    push("result2", 2'd3, 7'd6, 7'd1, 2'd0, 1'b0);
    press(4'd15);
    mult_listo_i = 1'b0;

    // Test 5b: confirm in RESULT clears everything
    push("restart_clear", 2'd0, 7'd0, 7'd0, 2'd0, 1'b0);  press(4'd15);

    // Test 3: third digit ignored, keys 12/13 ignored
    push("a_digit9", 2'd0, 7'd9, 7'd0, 2'd1, 1'b0);       press(4'd9);
    push("a_digit99", 2'd0, 7'd99, 7'd0, 2'd2, 1'b0);     press(4'd9);
    press(4'd9);
    check("max_dig_a", 32'(operando_a_o), 32'd99);
    check("max_dig_cnt", 32'(digitos_o), 32'd2);
    press(4'd12);
    press(4'd13);
    push("conf_a3", 2'd1, 7'd99, 7'd0, 2'd0, 1'b0);       press(4'd15);
    push("b_digit5", 2'd1, 7'd99, 7'd5, 2'd1, 1'b0);      press(4'd5);

    // Test 6: reset during the start cycle
    push("async_rst", 2'd0, 7'd0, 7'd0, 2'd0, 1'b0);
    @(posedge clk); #1;
    dato_i       = 4'd15;
    dato_listo_i = 1'b1;
    @(posedge clk); #2;
    check("pre_rst_start", 32'(mult_start_o), 32'd1);
    check("pre_rst_estado", 32'(estado_o), 32'd2);
    rst = 1'b0;
    #1;
    check("async_start", 32'(mult_start_o), 32'd0);
    check("async_estado", 32'(estado_o), 32'd0);
    check("async_a", 32'(operando_a_o), 32'd0);
    check("async_b", 32'(operando_b_o), 32'd0);
    check("async_dig", 32'(digitos_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 dato_listo_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    press(4'd12);
    press(4'd13);
    check("ign_keys_estado", 32'(estado_o), 32'd0);
    check("ign_keys_a", 32'(operando_a_o), 32'd0);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
